// File: rtl/fpu_mmio_responder_if.sv
// Data-memory port bundle between the pipeline memory stage (master) and the FP responder (slave).
interface fpu_mmio_responder_if;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        irq;

  modport master (output cs, we, addr, wdata, input rdata, busy, irq);
  modport slave  (input cs, we, addr, wdata, output rdata, busy, irq);
endinterface

// File: rtl/fpu_mmio_responder.sv
// Memory-mapped single-precision responder: iterative MUL, one-cycle NEG/ABS.
// Optional completion interrupt enabled by defining FPU_IRQ_EN.
module fpu_mmio_responder #(
  parameter int unsigned MUL_ITERS = 24,
  parameter logic [31:0] QNAN      = 32'h7FC0_0000
) (
  input logic                  clk,
  input logic                  reset,
  fpu_mmio_responder_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(MUL_ITERS + 1);

  typedef enum logic [2:0] {S_IDLE, S_SHORT, S_ITER, S_NORM, S_DONE} state_t;

  state_t             state_q;
  logic [31:0]        opa_q, opb_q, result_q, pend_q;
  logic [47:0]        mcand_q, acc_q;
  logic [23:0]        mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic signed [9:0]  exp_q;
  logic               sign_q, busy_q, done_q, err_q;

  logic wr, wr_op, accepted, illegal, ctrl_go, stat_wr;
  assign wr       = bus.cs & bus.we;
  assign wr_op    = wr & (bus.addr != 2'd3);
  assign accepted = wr_op & ~busy_q;
  assign illegal  = wr_op & busy_q;
  assign ctrl_go  = accepted & (bus.addr == 2'd2);
  assign stat_wr  = wr & (bus.addr == 2'd3);

  // Operand classification; denormals count as zero.
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        sgn, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, is_spec;
  logic [31:0] spec_res, short_res;
  assign ea     = opa_q[30:23];
  assign eb     = opb_q[30:23];
  assign ma     = opa_q[22:0];
  assign mb     = opb_q[22:0];
  assign sgn    = opa_q[31] ^ opb_q[31];
  assign zero_a = (ea == 8'h00);
  assign zero_b = (eb == 8'h00);
  assign inf_a  = (ea == 8'hFF) & (ma == '0);
  assign inf_b  = (eb == 8'hFF) & (mb == '0);
  assign nan_a  = (ea == 8'hFF) & (ma != '0);
  assign nan_b  = (eb == 8'hFF) & (mb != '0);
  assign is_spec = zero_a | zero_b | (ea == 8'hFF) | (eb == 8'hFF);

  always_comb begin
    spec_res = {sgn, 31'b0};
    if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a))
      spec_res = QNAN;
    else if (inf_a | inf_b)
      spec_res = {sgn, 8'hFF, 23'b0};
  end

  always_comb begin
    short_res = {~opa_q[31], opa_q[30:0]};
    case (bus.wdata[1:0])
      2'b00:   short_res = spec_res;
      2'b10:   short_res = {1'b0, opa_q[30:0]};
      default: short_res = {~opa_q[31], opa_q[30:0]};
    endcase
  end

  logic signed [9:0] exp_n;
  logic [22:0]       mant_n;
  logic [31:0]       norm_res;
  always_comb begin
    exp_n  = acc_q[47] ? exp_q + 10'sd1 : exp_q;
    mant_n = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
    if (exp_n >= 10'sd255)
      norm_res = {sign_q, 8'hFF, 23'b0};
    else if (exp_n <= 10'sd0)
      norm_res = {sign_q, 31'b0};
    else
      norm_res = {sign_q, exp_n[7:0], mant_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      pend_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (stat_wr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (illegal) err_q <= 1'b1;
      if (accepted && bus.addr == 2'd0) opa_q <= bus.wdata;
      if (accepted && bus.addr == 2'd1) opb_q <= bus.wdata;

      case (state_q)
        S_SHORT: begin
          result_q <= pend_q;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_ITER: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_NORM;
        end
        S_NORM: begin
          result_q <= norm_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: ;
      endcase

      // A new command overrides a same-edge one-cycle completion.
      if (ctrl_go) begin
        done_q <= 1'b0;
        if (bus.wdata[1:0] == 2'b00 && !is_spec) begin
          mcand_q  <= {24'b0, 1'b1, ma};
          mplier_q <= {1'b1, mb};
          acc_q    <= '0;
          cnt_q    <= CNT_W'(MUL_ITERS);
          exp_q    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
          sign_q   <= sgn;
          busy_q   <= 1'b1;
          state_q  <= S_ITER;
        end else begin
          pend_q  <= short_res;
          state_q <= S_SHORT;
        end
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.cs && !bus.we) begin
      case (bus.addr)
        2'd0:    bus.rdata = result_q;
        2'd1:    bus.rdata = opb_q;
        2'd3:    bus.rdata = {29'b0, err_q, done_q, busy_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  assign bus.busy = busy_q;

`ifdef FPU_IRQ_EN
  logic irq_q, done_rise;
  assign done_rise = (state_q == S_NORM) | ((state_q == S_SHORT) & ~ctrl_go);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (done_rise || illegal) begin
      irq_q <= 1'b1;
    end else if (stat_wr || ctrl_go) begin
      irq_q <= 1'b0;
    end
  end
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_mmio_responder.sv
// Directed bench for fpu_mmio_responder: vector table of operations plus timing corner sequences.
module tb_fpu_mmio_responder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

`ifdef FPU_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  fpu_mmio_responder_if bus ();

  fpu_mmio_responder #(.MUL_ITERS(24), .QNAN(32'h7FC0_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    d = bus.rdata;
    bus.cs = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 60; i++) begin
      rd(2'd3, s);
      if (s[1]) break;
    end
    check(name, s, 32'h2);
  endtask

  logic [31:0] d;
  int          n;

  initial begin
    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 2'b00, 32'h40C0_0000};
    vecs[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 2'b00, 32'h4010_0000};
    vecs[2]  = '{32'h7F80_0000, 32'h0000_0000, 2'b00, 32'h7FC0_0000};
    vecs[3]  = '{32'h7F00_0000, 32'h7F00_0000, 2'b00, 32'h7F80_0000};
    vecs[4]  = '{32'h0080_0000, 32'h0080_0000, 2'b00, 32'h0000_0000};
    vecs[5]  = '{32'h3F80_0000, 32'h0000_0000, 2'b01, 32'hBF80_0000};
    vecs[6]  = '{32'hBF80_0000, 32'h0000_0000, 2'b10, 32'h3F80_0000};
    vecs[7]  = '{32'h4000_0000, 32'h0000_0000, 2'b11, 32'hC000_0000};
    vecs[8]  = '{32'hC000_0000, 32'h4040_0000, 2'b00, 32'hC0C0_0000};
    vecs[9]  = '{32'h7FC0_0001, 32'h3F80_0000, 2'b00, 32'h7FC0_0000};
    vecs[10] = '{32'h7F80_0000, 32'hC000_0000, 2'b00, 32'hFF80_0000};
    vecs[11] = '{32'h8000_0000, 32'h40A0_0000, 2'b00, 32'h8000_0000};
    vecs[12] = '{32'h0000_0001, 32'h3F80_0000, 2'b00, 32'h0000_0000};
    vecs[13] = '{32'h3F80_0001, 32'h3F80_0001, 2'b00, 32'h3F80_0002};
    vecs[14] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 2'b00, 32'h407F_FFFE};
    vecs[15] = '{32'h7F00_0000, 32'h4000_0000, 2'b00, 32'h7F80_0000};
    vecs[16] = '{32'h7E80_0000, 32'h4000_0000, 2'b00, 32'h7F00_0000};
    vecs[17] = '{32'h0080_0000, 32'h3F80_0000, 2'b00, 32'h0080_0000};
    vecs[18] = '{32'h0080_0000, 32'h3F00_0000, 2'b00, 32'h0000_0000};
    vecs[19] = '{32'h3F80_0000, 32'h3F80_0000, 2'b00, 32'h3F80_0000};

    reset = 1'b1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_irq", {31'b0, bus.irq}, 32'h0);
    check("reset_rdata_idle", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd3, d);
    check("reset_status", d, 32'h0);
    rd(2'd0, d);
    check("reset_result", d, 32'h0);

    for (int i = 0; i < 20; i++) begin
      wr(2'd0, vecs[i].a);
      wr(2'd1, vecs[i].b);
      wr(2'd2, {30'b0, vecs[i].op});
      wait_done($sformatf("vec%0d_status", i));
      rd(2'd0, d);
      check($sformatf("vec%0d_result", i), d, vecs[i].exp);
    end

    // Read map and idle bus.
    rd(2'd1, d);
    check("read_opb", d, 32'h3F80_0000);
    rd(2'd2, d);
    check("read_ctrl_zero", d, 32'h0);
    @(negedge clk);
    check("rdata_unselected", bus.rdata, 32'h0);

    // MUL latency: busy for 25 cycles, irq on completion.
    wr(2'd0, 32'h4000_0000);
    wr(2'd1, 32'h4040_0000);
    wr(2'd2, 32'h0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    check("mul_busy_cycles", n, 32'd25);
    check("mul_irq_done", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    rd(2'd0, d);
    check("mul_result", d, 32'h40C0_0000);
    rd(2'd3, d);
    check("mul_status", d, 32'h2);
    check("irq_held", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    wr(2'd3, 32'h0);
    check("irq_clear_status", {31'b0, bus.irq}, 32'h0);

    // NEG lands exactly one edge after the CTRL write.
    wr(2'd0, 32'h3F80_0000);
    wr(2'd2, 32'h1);
    rd(2'd0, d);
    check("neg_not_yet", d, 32'h40C0_0000);
    rd(2'd0, d);
    check("neg_one_cycle", d, 32'hBF80_0000);

    // Illegal write during busy.
    wr(2'd0, 32'h4000_0000);
    wr(2'd1, 32'h4040_0000);
    wr(2'd2, 32'h0);
    repeat (4) @(posedge clk);
    wr(2'd0, 32'h1234_5678);
    rd(2'd3, d);
    check("err_during_busy", d, 32'h5);
    check("irq_illegal", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    n = 0;
    for (int i = 0; i < 60; i++) begin
      rd(2'd3, d);
      if (!d[0]) break;
    end
    check("err_after_busy", d, 32'h6);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d);
    check("status_cleared", d, 32'h0);
    wr(2'd2, 32'h1);
    wait_done("opa_kept_status");
    rd(2'd0, d);
    check("opa_kept", d, 32'hC000_0000);

    // STATUS write on the completion edge: done wins, err cleared.
    wr(2'd0, 32'h4000_0000);
    wr(2'd2, 32'h0);
    wr(2'd1, 32'h0);
    repeat (23) @(posedge clk);
    wr(2'd3, 32'h0);
    rd(2'd3, d);
    check("status_vs_complete", d, 32'h2);
    check("irq_vs_complete", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    rd(2'd0, d);
    check("status_vs_complete_res", d, 32'h40C0_0000);

    // Reset mid-operation.
    wr(2'd2, 32'h0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 2'd0;
    #1;
    check("rst_mid_result", bus.rdata, 32'h0);
    bus.addr = 2'd3;
    #1;
    check("rst_mid_status", bus.rdata, 32'h0);
    bus.cs = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wr(2'd0, 32'h4000_0000);
    wr(2'd1, 32'h4040_0000);
    wr(2'd2, 32'h0);
    wait_done("post_rst_status");
    rd(2'd0, d);
    check("post_rst_result", d, 32'h40C0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
